// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register offsets, bit positions and the default window base.
package mmio_pkg;

    localparam logic [7:0] MMIO_BASE_DEFAULT = 8'hF0;

    localparam logic [3:0] MMIO_STATUS    = 4'd0;
    localparam logic [3:0] MMIO_TXDATA    = 4'd1;
    localparam logic [3:0] MMIO_CYCLE     = 4'd2;
    localparam logic [3:0] MMIO_TIMER_CMP = 4'd3;
    localparam logic [3:0] MMIO_CTRL      = 4'd4;
    localparam logic [3:0] MMIO_HALT      = 4'd5;

    localparam int unsigned STATUS_FULL_BIT  = 0;
    localparam int unsigned STATUS_EMPTY_BIT = 1;
    localparam int unsigned STATUS_IRQ_BIT   = 2;
    localparam int unsigned STATUS_OVF_BIT   = 3;
    localparam int unsigned STATUS_COUNT_LSB = 4;
    localparam int unsigned STATUS_COUNT_W   = 4;

    localparam int unsigned CTRL_TIMER_EN_BIT = 0;

    // STATUS count field is 4 bits wide; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count4(input int unsigned count);
        return (count > 15) ? 4'hF : 4'(count);
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO for the console TX path; head is visible without bypass.
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Data-bus responder: claims a 16-word MMIO window (console FIFO, cycle counter,
// compare timer, halt flag) and passes every other access through to data memory.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(MMIO_BASE_DEFAULT),
    parameter int unsigned           FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  irq,
    output logic                  halt
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] rel_addr;
    logic [3:0]            offset;
    logic                  hit, wr_hit;
    logic                  wr_status, wr_txdata, wr_cmp, wr_ctrl, wr_halt;

    assign rel_addr  = data_address - MMIO_BASE;
    assign hit       = (data_address >= MMIO_BASE) && (rel_addr < ADDR_WIDTH'(16));
    assign offset    = rel_addr[3:0];
    assign wr_hit    = write_enable & hit;
    assign wr_status = wr_hit && (offset == MMIO_STATUS);
    assign wr_txdata = wr_hit && (offset == MMIO_TXDATA);
    assign wr_cmp    = wr_hit && (offset == MMIO_TIMER_CMP);
    assign wr_ctrl   = wr_hit && (offset == MMIO_CTRL);
    assign wr_halt   = wr_hit && (offset == MMIO_HALT);

    assign mem_write_enable = write_enable & ~hit;

    logic             fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign fifo_pop = tx_valid & tx_ready;
    assign tx_valid = ~fifo_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_txdata),
        .data_i  (write_data[7:0]),
        .pop_i   (fifo_pop),
        .head_o  (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    logic [DATA_WIDTH-1:0] cycle_q, cycle_d, cmp_q, cmp_d;
    logic                  timer_en_q, timer_en_d;
    logic                  irq_q, irq_d, ovf_q, ovf_d, halt_q, halt_d;

    // Next-state for counter, timer, sticky flags; timer set overrides a same-edge W1C.
    always_comb begin
        cycle_d    = cycle_q + DATA_WIDTH'(1);
        cmp_d      = cmp_q;
        timer_en_d = timer_en_q;
        irq_d      = irq_q;
        ovf_d      = ovf_q;
        halt_d     = halt_q;
        if (wr_status) begin
            if (write_data[STATUS_IRQ_BIT]) irq_d = 1'b0;
            if (write_data[STATUS_OVF_BIT]) ovf_d = 1'b0;
        end
        if (timer_en_q && (cycle_q == cmp_q)) irq_d = 1'b1;
        if (wr_txdata && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (wr_cmp) cmp_d = write_data;
        if (wr_ctrl) timer_en_d = write_data[CTRL_TIMER_EN_BIT];
        if (wr_halt) halt_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q    <= '0;
            cmp_q      <= '0;
            timer_en_q <= 1'b0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            cmp_q      <= cmp_d;
            timer_en_q <= timer_en_d;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
            halt_q     <= halt_d;
        end
    end

    assign irq  = irq_q;
    assign halt = halt_q;

    logic [DATA_WIDTH-1:0] reg_rdata;

    always_comb begin
        reg_rdata = '0;
        case (offset)
            MMIO_STATUS: begin
                reg_rdata[STATUS_FULL_BIT]  = fifo_full;
                reg_rdata[STATUS_EMPTY_BIT] = fifo_empty;
                reg_rdata[STATUS_IRQ_BIT]   = irq_q;
                reg_rdata[STATUS_OVF_BIT]   = ovf_q;
                reg_rdata[STATUS_COUNT_LSB +: STATUS_COUNT_W] = sat_count4(32'(fifo_count));
            end
            MMIO_CYCLE:     reg_rdata = cycle_q;
            MMIO_TIMER_CMP: reg_rdata = cmp_q;
            MMIO_CTRL:      reg_rdata[CTRL_TIMER_EN_BIT] = timer_en_q;
            MMIO_HALT:      reg_rdata[0] = halt_q;
            default:        reg_rdata = '0;
        endcase
    end

    assign read_data = hit ? reg_rdata : mem_read_data;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: decode vectors, FIFO/timer/halt/reset sequences and a
// randomized phase, all checked against a queue-based reference model.
module tb_mmio_responder;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] exp_rd;
        logic        exp_mwe;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;
    logic        halt;

    always #5 clk = ~clk;

    mmio_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .MMIO_BASE  (8'hF0),
        .FIFO_DEPTH (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .data_address     (data_address),
        .write_data       (write_data),
        .write_enable     (write_enable),
        .read_data        (read_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .irq              (irq),
        .halt             (halt)
    );

    // Stand-in for Data_Memory, driven only by the DUT's gated strobe.
    logic [31:0] env_mem [256] = '{default: 32'h0};
    assign mem_read_data = env_mem[data_address];
    always @(posedge clk) if (mem_write_enable) env_mem[data_address] <= write_data;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [31:0] m_cyc, m_cmp;
    logic        m_en, m_irq, m_ovf, m_halt;
    logic [7:0]  m_q[$];
    logic [31:0] m_mem [256] = '{default: 32'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [31:0] wd, input logic we, input logic rdy);
        data_address = a;
        write_data   = wd;
        write_enable = we;
        tx_ready     = rdy;
    endtask

    task automatic model_reset();
        m_cyc = 0; m_cmp = 0; m_en = 0; m_irq = 0; m_ovf = 0; m_halt = 0;
        m_q.delete();
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int unsigned n;
        n = m_q.size();
        if (a < 8'hF0) return m_mem[a];
        case (int'(a - 8'hF0))
            0:       return {24'b0, 4'((n > 15) ? 15 : n), m_ovf, m_irq, (n == 0), (n == 8)};
            2:       return m_cyc;
            3:       return m_cmp;
            4:       return {31'b0, m_en};
            5:       return {31'b0, m_halt};
            default: return 32'h0;
        endcase
    endfunction

    // Check all outputs against the model, advance the model by one edge, then clock.
    task automatic step();
        logic       hit, wr, pop, full, set_irq;
        logic [3:0] off;
        #1;
        chk("read_data", read_data, m_read(data_address));
        chk("mem_write_enable", 32'(mem_write_enable), 32'(write_enable && (data_address < 8'hF0)));
        chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("halt", 32'(halt), 32'(m_halt));
        hit     = (data_address >= 8'hF0);
        off     = 4'(data_address - 8'hF0);
        wr      = write_enable && hit;
        pop     = tx_ready && (m_q.size() != 0);
        full    = (m_q.size() == 8);
        set_irq = m_en && (m_cyc == m_cmp);
        if (wr && off == 0) begin
            if (write_data[2]) m_irq = 1'b0;
            if (write_data[3]) m_ovf = 1'b0;
        end
        if (set_irq) m_irq = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (wr && off == 1) begin
            if (!full || pop) m_q.push_back(write_data[7:0]);
            else m_ovf = 1'b1;
        end
        if (wr && off == 3) m_cmp = write_data;
        if (wr && off == 4) m_en = write_data[0];
        if (wr && off == 5) m_halt = 1'b1;
        if (write_enable && !hit) m_mem[data_address] = write_data;
        m_cyc = m_cyc + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = '{8'h10, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1};
        vecs[1] = '{8'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{8'hF4, 32'h0,        1'b1, 32'h0,        1'b0};
        vecs[3] = '{8'hF0, 32'h0,        1'b0, 32'h2,        1'b0};
        vecs[4] = '{8'hF1, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[5] = '{8'hFA, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0};
        vecs[6] = '{8'hFA, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[7] = '{8'hEF, 32'h12345678, 1'b1, 32'h0,        1'b1};
        vecs[8] = '{8'hEF, 32'h0,        1'b0, 32'h12345678, 1'b0};
        vecs[9] = '{8'hFF, 32'h0,        1'b0, 32'h0,        1'b0};

        reset = 1'b1;
        drive(8'hF2, 32'h0, 1'b1, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_cycle", read_data, 32'h0);
        chk("rst_mem_we", 32'(mem_write_enable), 32'h0);
        drive(8'hF2, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, 1'b0);
            #1;
            chk($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_mwe", i), 32'(mem_write_enable), 32'(vecs[i].exp_mwe));
            step();
        end

        // Fill, overflow, then drain in order.
        for (int i = 0; i < 8; i++) begin drive(8'hF1, 32'(32'h41 + i), 1'b1, 1'b0); step(); end
        drive(8'hF0, 32'h0, 1'b0, 1'b0); #1; chk("fifo_full_status", read_data, 32'h81); step();
        drive(8'hF1, 32'h49, 1'b1, 1'b0); step();
        drive(8'hF0, 32'h0, 1'b0, 1'b0); #1; chk("overflow_status", read_data, 32'h89); step();
        for (int i = 0; i < 8; i++) begin
            drive(8'h00, 32'h0, 1'b0, 1'b1); #1;
            chk($sformatf("drain%0d", i), 32'(tx_data), 32'(32'h41 + i));
            step();
        end
        drive(8'hF0, 32'h0, 1'b0, 1'b1); #1; chk("drained_status", read_data, 32'h0A); step();
        drive(8'hF0, 32'h8, 1'b1, 1'b0); step();
        drive(8'hF0, 32'h0, 1'b0, 1'b0); #1; chk("ovf_w1c_status", read_data, 32'h02); step();

        // Push into a full FIFO on the same edge as a pop.
        for (int i = 0; i < 8; i++) begin drive(8'hF1, 32'(32'h11 + i), 1'b1, 1'b0); step(); end
        drive(8'hF1, 32'h5A, 1'b1, 1'b1); step();
        drive(8'hF0, 32'h0, 1'b0, 1'b0); #1; chk("full_pop_status", read_data, 32'h81); step();
        for (int i = 0; i < 8; i++) begin
            drive(8'h00, 32'h0, 1'b0, 1'b1); #1;
            chk($sformatf("full_pop_drain%0d", i), 32'(tx_data), (i < 7) ? 32'(32'h12 + i) : 32'h5A);
            step();
        end
        drive(8'hF0, 32'h0, 1'b0, 1'b0); #1; chk("full_pop_empty", read_data, 32'h02); step();

        // Timer: compare 20 edges ahead of the CYCLE value seen on the CMP write.
        drive(8'hF3, m_cyc + 32'd20, 1'b1, 1'b0); step();
        drive(8'hF4, 32'h1, 1'b1, 1'b0); step();
        repeat (18) begin drive(8'h00, 32'h0, 1'b0, 1'b0); step(); end
        chk("irq_before_match", 32'(irq), 32'h0);
        step();
        chk("irq_at_match", 32'(irq), 32'h1);
        drive(8'hF0, 32'h4, 1'b1, 1'b0); step();
        chk("irq_w1c", 32'(irq), 32'h0);
        drive(8'hF3, m_cyc + 32'd3, 1'b1, 1'b0); step();
        drive(8'h00, 32'h0, 1'b0, 1'b0); step();
        step();
        drive(8'hF0, 32'h4, 1'b1, 1'b0); step();
        chk("irq_set_wins", 32'(irq), 32'h1);

        // Halt, then reset in the middle of a drain.
        drive(8'hF5, 32'h0, 1'b1, 1'b0); step();
        chk("halt_set", 32'(halt), 32'h1);
        for (int i = 0; i < 3; i++) begin drive(8'hF1, 32'(32'h61 + i), 1'b1, 1'b0); step(); end
        drive(8'h00, 32'h0, 1'b0, 1'b1); step();
        #2 reset = 1'b1;
        #1;
        chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
        chk("midrst_halt", 32'(halt), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        drive(8'hF2, 32'h0, 1'b0, 1'b0); #1;
        chk("cycle_after_reset", read_data, 32'h0);
        step();

        // Randomized traffic across the window and the passthrough range.
        for (int k = 0; k < 600; k++) begin
            logic [7:0]  a;
            logic [31:0] wd;
            if ($urandom_range(0, 1) != 0) a = 8'(32'hF0 + $urandom_range(0, 15));
            else a = 8'($urandom_range(0, 32'hEF));
            wd = $urandom;
            if (a == 8'hF3) wd = m_cyc + 32'($urandom_range(2, 25));
            drive(a, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Data-bus responder between the CPU data port and `Data_Memory`. It claims a small address window at the top of the data address space and passes all other accesses through to `Data_Memory` unchanged. Inside the window it provides:

- a console TX FIFO with a valid/ready drain;
- a free-running cycle counter;
- a compare timer with interrupt;
- a sticky halt flag, so benches can end on a program-driven halt rather than a fixed time limit.

## Interface

Parameters:
- `DATA_WIDTH`, 32, data bus width.
- `ADDR_WIDTH`, 8, data address width (word index).
- `MMIO_BASE`, 8'hF0, first address of the 16-word window `MMIO_BASE..MMIO_BASE+15`.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `data_address` in `ADDR_WIDTH`: CPU data address.
- `write_data` in `DATA_WIDTH`: CPU store data.
- `write_enable` in 1: CPU store strobe.
- `read_data` out `DATA_WIDTH`: load data returned to the CPU.
- `mem_write_enable` out 1: store strobe to `Data_Memory`, gated off inside the window.
- `mem_read_data` in `DATA_WIDTH`: `Data_Memory` read data.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: consumer accepts the head.
- `irq` out 1: timer interrupt pending.
- `halt` out 1: sticky program halt.

## Operation

- `hit` = `data_address` is in the window.
- `mem_write_enable` = `write_enable & !hit`.
- `read_data` = `hit` ? register read : `mem_read_data`. This path is purely combinational.

Register map (offset from `MMIO_BASE`):
- **0 STATUS**
  - Reads: bit0 fifo_full, bit1 fifo_empty, bit2 irq_pending, bit3 tx_overflow, bits[7:4] fifo_count (saturating at 15); all other bits 0.
  - Writes are W1C: bit2 clears irq_pending, bit3 clears tx_overflow.
- **1 TXDATA**
  - Write-only; reads return 0.
  - A write pushes `write_data[7:0]`.
  - If the FIFO is full and no pop occurs on the same edge, the byte is dropped and tx_overflow is set.
- **2 CYCLE**
  - Read-only `DATA_WIDTH` counter.
  - Increments every clock and wraps from all-ones to 0.
- **3 TIMER_CMP**
  - Read/write `DATA_WIDTH` compare value.
- **4 CTRL**
  - Read/write; bit0 timer_en. Other bits read 0.
- **5 HALT**
  - A write of any value sets `halt`.
  - `halt` stays set until `reset`.
  - Reads return {31'b0, halt}.
- **6–15**: reads return 0; writes are ignored.

Timer and interrupt:
- irq_pending is set on any edge where timer_en=1 and CYCLE==TIMER_CMP, using pre-edge values.
- `irq` = irq_pending.
- If a set and a W1C clear land on the same edge, the set wins.

FIFO behaviour:
- A pop occurs on an edge where `tx_valid & tx_ready`.
- Push into a full FIFO with a simultaneous pop is accepted; the count is unchanged.
- Push and pop on the same edge while non-full: the count is unchanged.
- `tx_data` is held stable while `tx_valid & !tx_ready`.
- There is no bypass: the first push into an empty FIFO raises `tx_valid` the next cycle.
- Pointers wrap modulo `FIFO_DEPTH`.

## Timing

- All register writes take effect at the `posedge clk` where `write_enable & hit`.
- Reads are valid in the same cycle as the address (zero latency).
- A read of CYCLE returns the pre-edge value. Two reads N cycles apart differ by N (mod 2^`DATA_WIDTH`).
- Reset values: `read_data` follows the mux; `mem_write_enable` follows `write_enable & !hit`; `tx_valid`=0, `tx_data`=0, `irq`=0, `halt`=0.
- Internal reset state: CYCLE=0, TIMER_CMP=0, CTRL=0, FIFO empty, overflow=0.
- Reset asserted mid-operation clears all of the above immediately (asynchronous), discarding any FIFO contents.

## Structure

- Shared package `mmio_pkg`:
  - register offset constants `MMIO_STATUS`, `MMIO_TXDATA`, `MMIO_CYCLE`, `MMIO_TIMER_CMP`, `MMIO_CTRL`, `MMIO_HALT`;
  - STATUS and CTRL bit-position constants;
  - default `MMIO_BASE`.
- One sub-module, `tx_fifo`: a synchronous FIFO, `FIFO_DEPTH`×8, with push/pop/full/empty/count.
- The top level holds the address decode, counter, timer, halt and read mux.

## Test plan

- **Passthrough:** store 0xDEADBEEF to address 0x10, then load 0x10. Expect `mem_write_enable`=1 and a readback of 0xDEADBEEF. A store to 0xF4 gives `mem_write_enable`=0.
- **FIFO:** with `tx_ready`=0, write 0x41..0x48 to TXDATA. Expect STATUS = 0x81 (count 8, full).
  - A 9th write (0x49) sets bit3; 0x49 is never output.
  - Then set `tx_ready`=1 and expect bytes 0x41..0x48 in order, after which STATUS bit1 = 1.
- **Full with simultaneous pop:** fill the FIFO, then push 0x5A on the same edge as a pop. Count stays 8, no overflow, and 0x5A is the last byte out.
- **Timer:** write TIMER_CMP = CYCLE+20, CTRL=1. Expect `irq`=1 exactly 20 edges later. W1C STATUS 0x4 drops `irq`. A clear coinciding with a match leaves `irq`=1.
- **Halt and reset:** write HALT to get `halt`=1. Assert `reset` mid-drain with 3 bytes queued. Expect `tx_valid`, `halt` and `irq` at 0 immediately and CYCLE reading 0 after release.
